// File: rtl/gpio_bus_master.sv
// Bus master that turns single commands into GPIO register accesses: write, read,
// and read-modify-write set-bits / clear-bits, with one command in flight at a time.
module gpio_bus_master #(
  parameter  int NUM_GPIO_SETS = 4,
  parameter  int GPIO_WIDTH    = 8,
  localparam int AW            = $clog2(NUM_GPIO_SETS) + 1,
  localparam int SW            = (NUM_GPIO_SETS > 1) ? $clog2(NUM_GPIO_SETS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic                  cmd_reg,
  input  logic [SW-1:0]         cmd_set,
  input  logic [GPIO_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [GPIO_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [AW-1:0]         gpio_addr,
  output logic [GPIO_WIDTH-1:0] gpio_wr_data,
  output logic                  gpio_wr_en,
  output logic                  gpio_rd_en,
  input  logic [GPIO_WIDTH-1:0] gpio_rd_data
);

  localparam logic [1:0]  OP_WRITE  = 2'b00;
  localparam logic [1:0]  OP_READ   = 2'b01;
  localparam logic [1:0]  OP_SET    = 2'b10;
  localparam logic [1:0]  OP_CLR    = 2'b11;
  localparam logic [SW:0] SET_LIMIT = (SW + 1)'(NUM_GPIO_SETS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t                  state_r;
  logic [1:0]              op_r;
  logic [GPIO_WIDTH-1:0]   mask_r;
  logic                    cmd_ready_r;
  logic                    rsp_valid_r;
  logic [GPIO_WIDTH-1:0]   rsp_data_r;
  logic                    rsp_err_r;
  logic [AW-1:0]           gpio_addr_r;
  logic [GPIO_WIDTH-1:0]   gpio_wr_data_r;
  logic                    gpio_wr_en_r;
  logic                    gpio_rd_en_r;

  logic [SW:0]             addr_full_s;
  logic                    in_range_s;

  function automatic logic [GPIO_WIDTH-1:0] rmw_value(
    input logic [1:0]            op,
    input logic [GPIO_WIDTH-1:0] cur,
    input logic [GPIO_WIDTH-1:0] mask
  );
    logic [GPIO_WIDTH-1:0] result;
    case (op)
      OP_SET:  result = cur | mask;
      OP_CLR:  result = cur & ~mask;
      default: result = cur;
    endcase
    return result;
  endfunction

  // The set index is widened by one bit so a power-of-two set count compares correctly.
  assign addr_full_s = {cmd_set, cmd_reg};
  assign in_range_s  = ({1'b0, cmd_set} < SET_LIMIT);

  // Command sequencer: all bus strobes and response fields are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      op_r           <= 2'b00;
      mask_r         <= '0;
      cmd_ready_r    <= 1'b0;
      rsp_valid_r    <= 1'b0;
      rsp_data_r     <= '0;
      rsp_err_r      <= 1'b0;
      gpio_addr_r    <= '0;
      gpio_wr_data_r <= '0;
      gpio_wr_en_r   <= 1'b0;
      gpio_rd_en_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          gpio_wr_en_r <= 1'b0;
          gpio_rd_en_r <= 1'b0;
          if (!cmd_ready_r) begin
            cmd_ready_r <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready_r <= 1'b0;
            op_r        <= cmd_op;
            mask_r      <= cmd_data;
            gpio_addr_r <= addr_full_s[AW-1:0];
            if (!in_range_s) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_data_r  <= '0;
            end else if (cmd_op == OP_WRITE) begin
              state_r        <= WR;
              rsp_err_r      <= 1'b0;
              gpio_wr_en_r   <= 1'b1;
              gpio_wr_data_r <= cmd_data;
            end else begin
              state_r      <= RD;
              rsp_err_r    <= 1'b0;
              gpio_rd_en_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          gpio_rd_en_r <= 1'b0;
          state_r      <= RD_WAIT;
        end
        // Read data arrives the cycle after the read strobe and is used right away.
        RD_WAIT: begin
          if (op_r == OP_READ) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= gpio_rd_data;
          end else begin
            state_r        <= WR;
            gpio_wr_en_r   <= 1'b1;
            gpio_wr_data_r <= rmw_value(op_r, gpio_rd_data, mask_r);
          end
        end
        WR: begin
          gpio_wr_en_r <= 1'b0;
          state_r      <= RESP;
          rsp_valid_r  <= 1'b1;
          rsp_data_r   <= gpio_wr_data_r;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r      <= IDLE;
          cmd_ready_r  <= 1'b0;
          rsp_valid_r  <= 1'b0;
          gpio_wr_en_r <= 1'b0;
          gpio_rd_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_err      = rsp_err_r;
  assign gpio_addr    = gpio_addr_r;
  assign gpio_wr_data = gpio_wr_data_r;
  assign gpio_wr_en   = gpio_wr_en_r;
  assign gpio_rd_en   = gpio_rd_en_r;

endmodule

// File: tb/tb_gpio_bus_master.sv
// Scoreboard bench for gpio_bus_master with a three-set GPIO register model.
module tb_gpio_bus_master;

  localparam int N = 3;

  typedef struct { bit wr; int cyc; logic [2:0] addr; logic [7:0] data; } strobe_t;
  typedef struct { logic [7:0] data; logic err; int cyc; int hold; } rsp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid, cmd_ready, cmd_reg;
  logic [1:0] cmd_op, cmd_set;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_data;
  logic [2:0] gpio_addr;
  logic [7:0] gpio_wr_data, gpio_rd_data;
  logic       gpio_wr_en, gpio_rd_en;

  logic [7:0] mem [8];
  logic       mem_load;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  strobe_t    strobe_q[$];
  rsp_t       rsp_q[$];
  strobe_t    s_e;
  rsp_t       cur;
  int         cnt;
  bit         in_rsp, hs_pending;
  int         hs_cyc;

  gpio_bus_master #(.NUM_GPIO_SETS(N), .GPIO_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_set(cmd_set), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .gpio_addr(gpio_addr), .gpio_wr_data(gpio_wr_data), .gpio_wr_en(gpio_wr_en),
    .gpio_rd_en(gpio_rd_en), .gpio_rd_data(gpio_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // GPIO register block model: write on strobe, read data valid the cycle after.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      mem[1] <= 8'h0F;
      mem[2] <= 8'h3C;
    end else if (gpio_wr_en) begin
      mem[gpio_addr] <= gpio_wr_data;
    end
    gpio_rd_data <= gpio_rd_en ? mem[gpio_addr] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Offer a command, wait for acceptance, queue the expected strobes and response.
  task automatic send(input logic [1:0] op, input logic rg, input logic [1:0] set,
                      input logic [7:0] data, input int hold, input bit b2b, output int acc);
    logic [2:0] addr;
    logic [7:0] curv, nv;
    int waited;
    cmd_op = op; cmd_reg = rg; cmd_set = set; cmd_data = data; cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    acc = cyc;
    if (!cmd_ready) begin
      check("accept_timeout", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    if (b2b) check("b2b_accept", acc, hs_cyc + 1);
    addr = {set, rg};
    curv = mem[addr];
    if (int'(set) >= N) begin
      rsp_q.push_back('{8'h00, 1'b1, acc + 1, hold});
    end else begin
      case (op)
        2'b00: begin
          strobe_q.push_back('{1'b1, acc + 1, addr, data});
          rsp_q.push_back('{data, 1'b0, acc + 2, hold});
        end
        2'b01: begin
          strobe_q.push_back('{1'b0, acc + 1, addr, 8'h00});
          rsp_q.push_back('{curv, 1'b0, acc + 3, hold});
        end
        default: begin
          nv = (op == 2'b10) ? (curv | data) : (curv & ~data);
          strobe_q.push_back('{1'b0, acc + 1, addr, 8'h00});
          strobe_q.push_back('{1'b1, acc + 3, addr, nv});
          rsp_q.push_back('{nv, 1'b0, acc + 4, hold});
        end
      endcase
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_reg   = 1'($urandom_range(0, 1));
    cmd_set   = 2'($urandom_range(0, 3));
    cmd_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(rsp_q.size() == 0 && strobe_q.size() == 0 && cmd_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_rsp_q", rsp_q.size(), 0);
  endtask

  // Monitor: pops expectations as strobes and responses appear, drives rsp_ready.
  initial begin
    rsp_ready = 1'b1; in_rsp = 1'b0; hs_pending = 1'b0; cnt = 0; hs_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_rsp = 1'b0; hs_pending = 1'b0; rsp_ready = 1'b1;
      end else begin
        if (gpio_wr_en || gpio_rd_en) begin
          if (strobe_q.size() == 0) begin
            check("strobe_unexp", {gpio_wr_en, gpio_rd_en}, 2'b00);
          end else begin
            s_e = strobe_q.pop_front();
            check("strobe_kind", {gpio_wr_en, gpio_rd_en}, s_e.wr ? 2'b10 : 2'b01);
            check("strobe_cyc", cyc, s_e.cyc);
            check("strobe_addr", gpio_addr, s_e.addr);
            if (s_e.wr) check("strobe_wdata", gpio_wr_data, s_e.data);
          end
        end
        if (hs_pending) begin
          check("rsp_drop", rsp_valid, 1'b0);
          check("idle_ready", cmd_ready, 1'b1);
          hs_pending = 1'b0;
        end else if (rsp_valid) begin
          if (!in_rsp) begin
            if (rsp_q.size() == 0) begin
              check("rsp_unexp", rsp_valid, 1'b0);
              cur = '{8'h00, 1'b0, cyc, 0};
            end else begin
              cur = rsp_q.pop_front();
              check("rsp_cyc", cyc, cur.cyc);
            end
            in_rsp = 1'b1;
            cnt = cur.hold;
          end
          check("rsp_data", rsp_data, cur.data);
          check("rsp_err", rsp_err, cur.err);
          check("rsp_cmd_ready", cmd_ready, 1'b0);
          if (cnt == 0) begin
            rsp_ready = 1'b1; hs_cyc = cyc; hs_pending = 1'b1; in_rsp = 1'b0;
          end else begin
            rsp_ready = 1'b0; cnt--;
          end
        end else begin
          rsp_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    logic [7:0] saved;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_reg = 1'b0; cmd_set = 2'b00; cmd_data = 8'h00;
    mem_load = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_ctrl", {cmd_ready, rsp_valid, rsp_err, gpio_wr_en, gpio_rd_en}, 5'b0);
    check("rst_data", {rsp_data, gpio_addr, gpio_wr_data}, 19'h0);
    repeat (3) @(negedge clk);
    mem_load = 1'b0;
    #2 rst = 1'b1;
    #1 check("rel_no_edge", cmd_ready, 1'b0);
    @(negedge clk);
    check("rel_ready", cmd_ready, 1'b1);

    send(2'b00, 1'b1, 2'd2, 8'hA5, 0, 1'b0, acc);   // write set 2 data
    send(2'b01, 1'b0, 2'd1, 8'h00, 0, 1'b0, acc);   // read set 1 dir
    send(2'b10, 1'b1, 2'd0, 8'hF0, 0, 1'b0, acc);   // set-bits 0F|F0
    send(2'b11, 1'b1, 2'd0, 8'h0C, 0, 1'b0, acc);   // clear-bits FF&~0C
    wait_idle();
    check("rmw_mem", mem[1], 8'hF3);
    check("wr_mem", mem[5], 8'hA5);

    // Stalled response, next command already offered
    send(2'b00, 1'b0, 2'd0, 8'h66, 5, 1'b0, acc);
    send(2'b01, 1'b1, 2'd2, 8'h00, 0, 1'b1, acc);
    // Out-of-range set
    send(2'b00, 1'b1, 2'd3, 8'h77, 0, 1'b0, acc);
    send(2'b10, 1'b0, 2'd3, 8'hFF, 2, 1'b0, acc);

    for (int i = 0; i < 12; i++) begin
      send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), $urandom_range(0, 2), 1'b0, acc);
    end
    wait_idle();

    // Reset while an RMW sits in RD_WAIT
    send(2'b11, 1'b1, 2'd0, 8'h00, 0, 1'b0, acc);
    wait_idle();
    saved = mem[1];
    send(2'b10, 1'b1, 2'd0, ~saved, 0, 1'b0, acc);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ctrl", {cmd_ready, rsp_valid, rsp_err, gpio_wr_en, gpio_rd_en}, 5'b0);
    check("mid_rst_data", {rsp_data, gpio_addr, gpio_wr_data}, 19'h0);
    strobe_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("mid_rel_no_edge", cmd_ready, 1'b0);
    @(negedge clk);
    check("mid_rel_ready", cmd_ready, 1'b1);
    repeat (4) @(negedge clk);
    check("rst_no_write", mem[1], saved);
    send(2'b01, 1'b1, 2'd0, 8'h00, 0, 1'b0, acc);
    wait_idle();
    check("drain_strobe", strobe_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
